shift_add_multiplier: RTL and testbench

SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

---
 rtl/shift_add_multiplier_pkg.sv | 13 +
 rtl/eightBitAdder.sv | 12 +
 rtl/shift_add_multiplier.sv | 83 ++++++++
 tb/tb_shift_add_multiplier.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/shift_add_multiplier_pkg.sv
// rtl/shift_add_multiplier_pkg.sv - shared FSM encoding and iteration constants for the shift-add multiplier
package shift_add_multiplier_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int ITERATIONS = 8;
    localparam int CNT_W      = $clog2(ITERATIONS);

endpackage

// File: rtl/eightBitAdder.sv
// rtl/eightBitAdder.sv - 8-bit ripple-style adder with carry in and carry out
module eightBitAdder (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {8'd0, cin};

endmodule

// File: rtl/shift_add_multiplier.sv
// rtl/shift_add_multiplier.sv - 8x8 unsigned sequential shift-and-add multiplier
// One partial product per RUN cycle; the multiplier bits are consumed from P[0].
module shift_add_multiplier
    import shift_add_multiplier_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        busy,
    output logic        done,
    output logic [15:0] product
);

    state_t             state;
    state_t             state_next;
    logic [7:0]         mcand;
    logic [15:0]        p;
    logic [CNT_W-1:0]   cnt;
    logic [7:0]         addend;
    logic [7:0]         s;
    logic               c;

    assign addend  = p[0] ? mcand : 8'd0;
    assign product = p;

    eightBitAdder u_adder (
        .a    (p[15:8]),
        .b    (addend),
        .cin  (1'b0),
        .sum  (s),
        .cout (c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (cnt == CNT_W'(ITERATIONS - 1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // Carry joins the sum as the new top bit, so the shift never loses an overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand <= 8'd0;
            p     <= 16'd0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand <= a;
                        p     <= {8'd0, b};
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    p   <= {c, s, p[7:1]};
                    cnt <= cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb/tb_shift_add_multiplier.sv - self-checking bench for shift_add_multiplier
module tb_shift_add_multiplier;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] product;

    int checks = 0;
    int errors = 0;

    shift_add_multiplier dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [7:0] ra, input logic [7:0] rb, input int inject, input string tag);
        logic [15:0] exp;
        int          busy_cnt;
        int          lat;
        bit          overlap;
        exp      = {8'd0, ra} * {8'd0, rb};
        a        = ra;
        b        = rb;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        a        = 8'($urandom);
        b        = 8'($urandom);
        busy_cnt = busy ? 1 : 0;
        lat      = 0;
        overlap  = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            if (n == inject) begin
                start = 1'b1;
                a     = 8'd9;
                b     = 8'd9;
            end
            tick();
            start = 1'b0;
            if (busy && done) overlap = 1'b1;
            if (done) begin
                lat = n;
                break;
            end
            if (busy) busy_cnt++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd8);
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd8);
        check({tag, "_product"}, 32'(product), 32'(exp));
        check({tag, "_overlap"}, 32'(overlap), 32'd0);
        tick();
        check({tag, "_done_after"}, 32'(done), 32'd0);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        a = 8'($urandom);
        b = 8'($urandom);
        tick();
        tick();
        check({tag, "_product_held"}, 32'(product), 32'(exp));
    endtask

    initial begin
        int          pulses;
        int          first_pulse;
        logic [7:0]  ra;
        logic [7:0]  rb;

        rst   = 1'b1;
        start = 1'b0;
        a     = 8'd0;
        b     = 8'd0;
        tick();
        tick();
        check("reset_product", 32'(product), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        rst = 1'b0;

        run_op(8'd13, 8'd11, -1, "case1");
        run_op(8'd255, 8'd255, -1, "case2");
        run_op(8'd0, 8'd200, -1, "case3a");
        run_op(8'd200, 8'd0, -1, "case3b");

        run_op(8'd7, 8'd6, 3, "case4");
        pulses = 0;
        for (int n = 0; n < 12; n++) begin
            tick();
            if (done) pulses++;
        end
        check("case4_no_second_done", 32'(pulses), 32'd0);
        check("case4_product_kept", 32'(product), 32'h002A);

        a     = 8'd100;
        b     = 8'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        #1;
        check("case5_abort_product", 32'(product), 32'd0);
        check("case5_abort_busy", 32'(busy), 32'd0);
        check("case5_abort_done", 32'(done), 32'd0);
        tick();
        tick();
        rst    = 1'b0;
        pulses = 0;
        for (int n = 0; n < 12; n++) begin
            tick();
            if (done) pulses++;
        end
        check("case5_no_done", 32'(pulses), 32'd0);
        run_op(8'd2, 8'd3, -1, "case5_after");

        a           = 8'd16;
        b           = 8'd16;
        start       = 1'b1;
        tick();
        pulses      = 0;
        first_pulse = -1;
        for (int n = 1; n <= 30; n++) begin
            tick();
            if (done) begin
                if (first_pulse < 0) first_pulse = n;
                check("case6_pulse_spacing", 32'((n - 8) % 10), 32'd0);
                check("case6_product", 32'(product), 32'h0100);
                pulses++;
            end
        end
        start = 1'b0;
        check("case6_first_pulse", 32'(first_pulse), 32'd8);
        check("case6_pulse_count", 32'(pulses), 32'd3);
        repeat (12) tick();

        for (int i = 0; i < 20; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            run_op(ra, rb, -1, "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
